// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared types and arithmetic helpers for the Goertzel bank.
//   state_t    - engine FSM states
//   MAXW       - working width of the saturation helpers
//   q_shift()  - Q-format alignment shift for a Q2.(COEF_W-2) coefficient
//   sat_s()    - saturate a signed value to w bits
//   sat_u()    - clamp a signed value into the unsigned w-bit range
package goertzel_pkg;

  typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_ITER, ST_POW, ST_OUT} state_t;

  localparam int MAXW = 128;

  function automatic int q_shift(input int coef_w);
    return coef_w - 2;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_s(input logic signed [MAXW-1:0] v,
                                                   input int w);
    logic signed [MAXW-1:0] hi;
    hi = $signed((MAXW'(1) << (w - 1)) - MAXW'(1));
    if (v > hi) return hi;
    if (v < ~hi) return ~hi;   // ~hi == -(2^(w-1))
    return v;
  endfunction

  // Negative inputs clamp to zero, large ones to 2^w-1.
  function automatic logic signed [MAXW-1:0] sat_u(input logic signed [MAXW-1:0] v,
                                                   input int w);
    logic signed [MAXW-1:0] hi;
    hi = $signed((MAXW'(1) << w) - MAXW'(1));
    if (v < 0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/goertzel_mac.sv
// goertzel_mac: shared combinational datapath of the bank.
//   x, coef, s1, s2 : current sample, bin coefficient and bin state
//   s0, s0_sat      : next recursion value (saturated to ACC_W) and its overflow flag
//   power           : s1^2 + s2^2 - coef*s1*s2, clamped, shifted, saturated to OUT_W
module goertzel_mac import goertzel_pkg::*; #(
  parameter int SAMPLE_W  = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int POW_SHIFT = 0
) (
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [COEF_W-1:0]   coef,
  input  logic signed [ACC_W-1:0]    s1,
  input  logic signed [ACC_W-1:0]    s2,
  output logic signed [ACC_W-1:0]    s0,
  output logic                       s0_sat,
  output logic        [OUT_W-1:0]    power
);
  localparam int QS = q_shift(COEF_W);
  localparam int MW = COEF_W + ACC_W;
  localparam int SW = ACC_W + 3;      // x + 2*s1 - s2 never exceeds this
  localparam int PW = 2 * ACC_W + 2;

  logic signed [MW-1:0]    prod;
  logic signed [ACC_W+1:0] cs1;       // (coef*s1) >>> QS, |cs1| <= 2^ACC_W
  logic signed [SW-1:0]    s0_w;
  logic signed [PW-1:0]    p_w, p_sh;

  assign prod   = MW'(coef) * MW'(s1);
  assign cs1    = (ACC_W+2)'(prod >>> QS);
  assign s0_w   = SW'(x) + SW'(cs1) - SW'(s2);
  assign s0     = ACC_W'(sat_s(MAXW'(s0_w), ACC_W));
  assign s0_sat = (SW'(s0) != s0_w);

  assign p_w    = PW'(s1) * PW'(s1) + PW'(s2) * PW'(s2) - PW'(cs1) * PW'(s2);
  assign p_sh   = p_w >>> POW_SHIFT;
  assign power  = OUT_W'(sat_u(MAXW'(p_sh), OUT_W));

endmodule

// File: rtl/goertzel_bank.sv
// goertzel_bank: time-multiplexed NUM_BINS-bin Goertzel engine.
//   in_valid/in_ready/in_sample  : one sample per handshake, NUM_BINS cycles per sample
//   frame_abort                  : drop the frame, re-clear bin state
//   coef_wr_*                    : coefficient RAM write (only idle, frame not started)
//   coef_wr_err                  : pulse one cycle after a rejected write
//   out_valid/out_ready/out_*    : one power value per bin at frame end
//   acc_sat                      : sticky recursion saturation within the frame
//   busy                         : engine not idle
module goertzel_bank import goertzel_pkg::*; #(
  parameter int NUM_BINS  = 32,
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_W  = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int POW_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SAMPLE_W-1:0]  in_sample,
  input  logic                        frame_abort,
  input  logic                        coef_wr_en,
  input  logic [$clog2(NUM_BINS)-1:0] coef_wr_addr,
  input  logic signed [COEF_W-1:0]    coef_wr_data,
  output logic                        coef_wr_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_power,
  output logic [$clog2(NUM_BINS)-1:0] out_bin,
  output logic                        out_last,
  output logic                        acc_sat,
  output logic                        busy
);
  localparam int BW = $clog2(NUM_BINS);
  localparam int CW = $clog2(FRAME_LEN + 1);

  state_t                     state;
  logic [BW-1:0]              bin, coef_addr;
  logic [CW-1:0]              cnt;
  logic signed [SAMPLE_W-1:0] x_q;
  logic                       ov_q;

  logic signed [ACC_W-1:0]  s1_ram   [NUM_BINS];
  logic signed [ACC_W-1:0]  s2_ram   [NUM_BINS];
  logic signed [COEF_W-1:0] coef_ram [NUM_BINS];

  logic signed [ACC_W-1:0]  s1_rd, s2_rd, s0, s1_wd, s2_wd;
  logic signed [COEF_W-1:0] coef_rd;
  logic                     s0_sat, ram_we, coef_we, last_bin;
  logic [OUT_W-1:0]         pw;

  assign last_bin = (bin == BW'(NUM_BINS - 1));
  assign coef_we  = coef_wr_en && (state == ST_IDLE) && (cnt == '0) &&
                    (int'(coef_wr_addr) < NUM_BINS);
  // Coefficient writes only happen while idle, when no bin is read, so a
  // single shared address keeps the coefficient store single-ported.
  assign coef_addr = coef_we ? coef_wr_addr : bin;

  assign s1_rd   = s1_ram[bin];
  assign s2_rd   = s2_ram[bin];
  assign coef_rd = coef_ram[coef_addr];

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = ov_q && !frame_abort;   // abort retracts the offer at once

  goertzel_mac #(
    .SAMPLE_W(SAMPLE_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .POW_SHIFT(POW_SHIFT)
  ) u_mac (
    .x(x_q), .coef(coef_rd), .s1(s1_rd), .s2(s2_rd),
    .s0(s0), .s0_sat(s0_sat), .power(pw)
  );

  // CLEAR and POW zero the addressed bin; ITER shifts the recursion.
  always_comb begin
    ram_we = 1'b0;
    s1_wd  = '0;
    s2_wd  = '0;
    case (state)
      ST_CLEAR, ST_POW: ram_we = 1'b1;
      ST_ITER: begin
        ram_we = 1'b1;
        s1_wd  = s0;
        s2_wd  = s1_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      s1_ram[bin] <= s1_wd;
      s2_ram[bin] <= s2_wd;
    end
    if (coef_we) coef_ram[coef_addr] <= coef_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      bin         <= '0;
      cnt         <= '0;
      x_q         <= '0;
      ov_q        <= 1'b0;
      acc_sat     <= 1'b0;
      coef_wr_err <= 1'b0;
      out_power   <= '0;
      out_bin     <= '0;
      out_last    <= 1'b0;
    end else begin
      coef_wr_err <= coef_wr_en && !coef_we;
      if (frame_abort && state != ST_CLEAR) begin
        state <= ST_CLEAR;
        bin   <= '0;
        ov_q  <= 1'b0;
      end else begin
        case (state)
          ST_CLEAR: begin
            cnt     <= '0;
            acc_sat <= 1'b0;
            if (last_bin) begin
              bin   <= '0;
              state <= ST_IDLE;
            end else bin <= bin + 1'b1;
          end
          ST_IDLE: if (in_valid) begin
            x_q   <= in_sample;
            state <= ST_ITER;
          end
          ST_ITER: begin
            if (s0_sat) acc_sat <= 1'b1;
            if (last_bin) begin
              bin   <= '0;
              cnt   <= cnt + 1'b1;
              state <= (cnt + 1'b1 == CW'(FRAME_LEN)) ? ST_POW : ST_IDLE;
            end else bin <= bin + 1'b1;
          end
          ST_POW: begin
            out_power <= pw;
            out_bin   <= bin;
            out_last  <= last_bin;
            ov_q      <= 1'b1;
            state     <= ST_OUT;
          end
          ST_OUT: if (out_ready) begin
            ov_q <= 1'b0;
            if (out_last) begin
              bin     <= '0;
              cnt     <= '0;
              acc_sat <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              bin   <= bin + 1'b1;
              state <= ST_POW;
            end
          end
          default: state <= ST_CLEAR;
        endcase
      end
    end
  end

endmodule
